// File: rtl/mulu_unit_if.sv
// rtl/mulu_unit_if.sv - operand/product bundle for the sequential unsigned multiplier
interface mulu_unit_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] c;
  logic               busy;
  logic               valid;

  modport master (output a, output b, input c, input busy, input valid);
  modport slave  (input a, input b, output c, output busy, output valid);
endinterface

// File: rtl/mulu_unit.sv
// rtl/mulu_unit.sv - iterative shift-and-add unsigned multiplier, recomputes on operand change
// Define MULU_RADIX4_EN to retire two multiplier bits per cycle (WIDTH/2 latency).
module mulu_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  mulu_unit_if.slave bus
);

`ifdef MULU_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int ITERS = WIDTH / STEP;
  localparam int CW    = $clog2(ITERS) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_cap_q, a_cap_d;
  logic [WIDTH-1:0]   b_cap_q, b_cap_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] c_q, c_d;
  logic               valid_q, valid_d;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_step;

  // Partial product selected by the low multiplier bit(s) this iteration.
  always_comb begin
    addend = '0;
`ifdef MULU_RADIX4_EN
    case (mplier_q[1:0])
      2'd1:    addend = mcand_q;
      2'd2:    addend = mcand_q << 1;
      2'd3:    addend = mcand_q + (mcand_q << 1);
      default: addend = '0;
    endcase
`else
    if (mplier_q[0]) addend = mcand_q;
`endif
  end

  assign acc_step = acc_q + addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_cap_q  <= '0;
      b_cap_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      c_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_cap_q  <= a_cap_d;
      b_cap_q  <= b_cap_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_cap_d  = a_cap_q;
    b_cap_d  = b_cap_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if ({bus.a, bus.b} != {a_cap_q, b_cap_q}) begin
          a_cap_d  = bus.a;
          b_cap_d  = bus.b;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          c_d     = acc_step;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.c     = c_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_mulu_unit.sv
// tb/tb_mulu_unit.sv - self-checking bench for mulu_unit: directed table, corner sequences, random products
module tb_mulu_unit;
  localparam int W = 32;
`ifdef MULU_RADIX4_EN
  localparam int ITERS = W / 2;
`else
  localparam int ITERS = W;
`endif

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  mulu_unit_if #(.WIDTH(W)) bus ();
  mulu_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] c;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [W-1:0] na, input logic [W-1:0] nb);
    @(negedge clk);
    bus.a = na;
    bus.b = nb;
  endtask

  // Capture is assumed on the next rising edge; optionally alter a mid-run.
  task automatic wait_result(input logic [2*W-1:0] exp, input string name,
                             input int chg_at = 0, input logic [W-1:0] chg_a = '0);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= ITERS + 8; i++) begin
      @(negedge clk);
      if (i == 1) check({name, " busy_rise"}, 64'(bus.busy), 64'd1);
      if (chg_at != 0 && i == chg_at) bus.a = chg_a;
      if (bus.valid) begin
        n = i;
        seen = 1'b1;
        break;
      end
    end
    if (seen) begin
      check({name, " latency"}, 64'(n - 1), 64'(ITERS));
      check({name, " product"}, bus.c, exp);
      check({name, " busy_fall"}, 64'(bus.busy), 64'd0);
    end else begin
      check({name, " timeout"}, 64'(seen), 64'd1);
    end
  endtask

  task automatic check_idle(input logic [2*W-1:0] exp, input string name);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({name, " idle_valid"}, 64'(bus.valid), 64'd0);
      check({name, " idle_busy"}, 64'(bus.busy), 64'd0);
      check({name, " idle_c"}, bus.c, exp);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb, cur_a, cur_b;
    bit stray;
    vectors = 0;
    miscompares = 0;

    tbl[0] = '{a: 32'd6,          b: 32'd12,         c: 64'd72};
    tbl[1] = '{a: 32'd6,          b: 32'd5,          c: 64'd30};
    tbl[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  c: 64'hFFFF_FFFE_0000_0001};
    tbl[3] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          c: 64'h0000_0000_FFFF_FFFF};
    tbl[4] = '{a: 32'd0,          b: 32'd5,          c: 64'd0};
    tbl[5] = '{a: 32'h8000_0000,  b: 32'd2,          c: 64'h1_0000_0000};

    // 0x0 after reset matches the cleared capture registers: no computation.
    rst = 1'b1;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle(64'd0, "zero_after_reset");

    rst = 1'b1;
    bus.a = 32'd9;
    bus.b = 32'd12;
    repeat (2) @(negedge clk);
    check("reset c", bus.c, 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset valid", 64'(bus.valid), 64'd0);
    rst = 1'b0;
    wait_result(64'd108, "first_9x12");
    check_idle(64'd108, "first_9x12");

    for (int k = 0; k < 6; k++) begin
      apply(tbl[k].a, tbl[k].b);
      wait_result(tbl[k].c, $sformatf("tbl%0d", k));
      check_idle(tbl[k].c, $sformatf("tbl%0d", k));
    end

    // Operand change during RUN is ignored, then picked up on return to IDLE.
    apply(32'd7, 32'd11);
    wait_result(64'd77, "midrun_7x11", 6, 32'd3);
    wait_result(64'd33, "restart_3x11");
    check_idle(64'd33, "restart_3x11");

    // Abort after ten iterations.
    apply(32'd5, 32'd7);
    stray = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (bus.valid) stray = 1'b1;
    end
    check("abort no_early_valid", 64'(stray), 64'd0);
    rst = 1'b1;
    bus.a = 32'd9;
    bus.b = 32'd12;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort c", bus.c, 64'd0);
      check("abort busy", 64'(bus.busy), 64'd0);
      check("abort valid", 64'(bus.valid), 64'd0);
    end
    rst = 1'b0;
    wait_result(64'd108, "after_abort_9x12");
    check_idle(64'd108, "after_abort_9x12");

    cur_a = 32'd9;
    cur_b = 32'd12;
    for (int k = 0; k < 16; k++) begin
      do begin
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 3))
          0: ra = ra & 32'h0000_00FF;
          1: rb = rb & 32'h0000_0001;
          2: ra = ra | 32'hFFFF_0000;
          default: ;
        endcase
      end while ({ra, rb} == {cur_a, cur_b});
      apply(ra, rb);
      wait_result(64'(ra) * 64'(rb), $sformatf("rand%0d", k));
      check_idle(64'(ra) * 64'(rb), $sformatf("rand%0d", k));
      cur_a = ra;
      cur_b = rb;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
